// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction size, decode bubble encoding and decode-side bundle.
package fetch_pkg;

    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_out_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register and next-address selection: redirect mux, word alignment and sequential +4 step.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              issue,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] pc;
    logic              unused_lsbs;

    // Redirect targets are forced onto a word boundary; the low bits carry no meaning.
    assign unused_lsbs = ^redirect_pc[1:0];
    assign addr        = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : pc;

    // The +4 step wraps naturally at the top of the address space.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (issue) begin
            pc <= addr + ADDR_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage in front of a 1-cycle BRAM: issues reads, tracks the in-flight word, hands off to decode.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalled
);

    logic              advance;
    logic              issue;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_pc;

    fetch_pc_gen #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_gen (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .issue          (issue),
        .addr           (imem_addr)
    );

    assign instr_valid = pend_valid && !rst;
    assign advance     = !instr_valid || instr_ready;
    // A redirect always issues, even under backpressure, so the held word is dropped.
    assign issue       = !rst && (advance || redirect_valid);
    assign imem_en     = issue;
    assign instr       = imem_data;
    assign instr_pc    = rst ? '0 : pend_pc;

    // Read-issue to data-return boundary: pend_* describe the word the BRAM is presenting.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
        end else if (issue) begin
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pend_pc <= imem_addr;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt;
    logic [31:0] stalled_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // An instruction squashed by a same-cycle redirect is not an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_cnt <= '0;
            stalled_cnt <= '0;
        end else begin
            if (instr_valid && instr_ready && !redirect_valid) fetched_cnt <= sat_inc(fetched_cnt);
            if (instr_valid && !instr_ready)                   stalled_cnt <= sat_inc(stalled_cnt);
        end
    end

    assign perf_fetched = rst ? '0 : fetched_cnt;
    assign perf_stalled = rst ? '0 : stalled_cnt;
`else
    assign perf_fetched = '0;
    assign perf_stalled = '0;
`endif

endmodule
